// File: rtl/motor_control_regfile.sv
// Avalon-MM register bank for N motor channels: PID/limit/mode configuration,
// latched UART status words, and a tick-driven streamer of changed configurations.
module motor_control_regfile #(
    parameter int NUMBER_OF_MOTORS     = 6,
    parameter int UPDATE_PERIOD_CYCLES = 500000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] address,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic        read,
    output logic [31:0] readdata,
    output logic        waitrequest,
    input  logic        status_valid,
    input  logic [7:0]  status_motor,
    input  logic [31:0] status_position,
    input  logic [31:0] status_velocity,
    input  logic [15:0] status_current,
    input  logic [31:0] status_displacement,
    output logic        cfg_valid,
    input  logic        cfg_ready,
    output logic [7:0]  cfg_motor,
    output logic [2:0]  cfg_word,
    output logic [31:0] cfg_data,
    output logic        cfg_last
);

    localparam int IW = (NUMBER_OF_MOTORS > 1) ? $clog2(NUMBER_OF_MOTORS) : 1;
    localparam int CW = $clog2(UPDATE_PERIOD_CYCLES);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUMBER_OF_MOTORS - 1);
    localparam logic [7:0]    N8       = 8'(NUMBER_OF_MOTORS);
    localparam logic [CW-1:0] CNT_MAX  = CW'(UPDATE_PERIOD_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_SEND
    } state_t;

    // Configuration words 0..6 (Kp .. deadband) plus the 3-bit mode word
    logic [31:0] r_cfg  [7][NUMBER_OF_MOTORS];
    logic [2:0]  r_mode [NUMBER_OF_MOTORS];
    logic [31:0] r_pos  [NUMBER_OF_MOTORS];
    logic [31:0] r_vel  [NUMBER_OF_MOTORS];
    logic [15:0] r_cur  [NUMBER_OF_MOTORS];
    logic [31:0] r_disp [NUMBER_OF_MOTORS];

    logic [NUMBER_OF_MOTORS-1:0] r_dirty;
    logic                        r_update_enable;
    logic [31:0]                 r_frames_sent;
    logic [31:0]                 r_readdata;
    logic                        r_rd_phase;
    logic [CW-1:0]               r_cnt;
    logic                        r_tick_pending;
    state_t                      r_state;
    logic [IW-1:0]               r_idx;
    logic [2:0]                  r_word;

    logic [7:0]                  w_sel;
    logic [7:0]                  w_mot;
    logic                        w_mot_ok;
    logic [IW-1:0]               w_mi;
    logic                        w_wr_cfg;
    logic                        w_rd_start;
    logic [31:0]                 w_rd_val;
    logic                        w_tick;
    logic                        w_st_ok;
    logic [IW-1:0]               w_st_mi;
    state_t                      w_state_nxt;
    logic [IW-1:0]               w_idx_nxt;
    logic [2:0]                  w_word_nxt;
    logic                        w_consume;
    logic                        w_clr_cur;
    logic                        w_frame_done;
    logic [NUMBER_OF_MOTORS-1:0] w_set_mask;
    logic [NUMBER_OF_MOTORS-1:0] w_clr_mask;

    assign w_sel      = address[15:8];
    assign w_mot      = address[7:0];
    assign w_mot_ok   = (w_mot < N8);
    assign w_mi       = w_mot[IW-1:0];
    assign w_wr_cfg   = write && w_mot_ok && (w_sel <= 8'h07);
    assign w_rd_start = read && !r_rd_phase;
    assign w_tick     = (r_cnt == CNT_MAX);
    assign w_st_ok    = status_valid && (status_motor < N8);
    assign w_st_mi    = status_motor[IW-1:0];

    assign waitrequest = w_rd_start;
    assign readdata    = r_readdata;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int m = 0; m < NUMBER_OF_MOTORS; m++) begin
                for (int s = 0; s < 7; s++) begin
                    r_cfg[s][m] <= '0;
                end
                r_mode[m] <= '0;
            end
        end else if (w_wr_cfg) begin
            if (w_sel[2:0] == 3'd7) begin
                r_mode[w_mi] <= writedata[2:0];
            end else begin
                r_cfg[w_sel[2:0]][w_mi] <= writedata;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int m = 0; m < NUMBER_OF_MOTORS; m++) begin
                r_pos[m]  <= '0;
                r_vel[m]  <= '0;
                r_cur[m]  <= '0;
                r_disp[m] <= '0;
            end
        end else if (w_st_ok) begin
            r_pos[w_st_mi]  <= status_position;
            r_vel[w_st_mi]  <= status_velocity;
            r_cur[w_st_mi]  <= status_current;
            r_disp[w_st_mi] <= status_displacement;
        end
    end

    always_comb begin
        w_rd_val = 32'hDEADBEEF;
        if (w_sel == 8'h10) begin
            w_rd_val = {31'd0, r_update_enable};
        end else if (w_sel == 8'h11) begin
            w_rd_val = r_frames_sent;
        end else if (w_mot_ok) begin
            case (w_sel)
                8'h00, 8'h01, 8'h02, 8'h03,
                8'h04, 8'h05, 8'h06: w_rd_val = r_cfg[w_sel[2:0]][w_mi];
                8'h07:               w_rd_val = {29'd0, r_mode[w_mi]};
                8'h08:               w_rd_val = r_pos[w_mi];
                8'h09:               w_rd_val = r_vel[w_mi];
                8'h0A:               w_rd_val = {{16{r_cur[w_mi][15]}}, r_cur[w_mi]};
                8'h0B:               w_rd_val = r_disp[w_mi];
                default:             w_rd_val = 32'hDEADBEEF;
            endcase
        end
    end

    // One wait state: capture on the first read cycle, release on the second
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_readdata <= '0;
            r_rd_phase <= 1'b0;
        end else if (w_rd_start) begin
            r_readdata <= w_rd_val;
            r_rd_phase <= 1'b1;
        end else if (r_rd_phase) begin
            r_rd_phase <= 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_update_enable <= 1'b0;
            r_frames_sent   <= '0;
        end else begin
            if (write && (w_sel == 8'h10)) begin
                r_update_enable <= writedata[0];
            end
            if (w_frame_done) begin
                r_frames_sent <= r_frames_sent + 32'd1;
            end
        end
    end

    // A tick arriving while one is still pending (or being consumed) is dropped
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt          <= '0;
            r_tick_pending <= 1'b0;
        end else begin
            r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
            if (w_consume) begin
                r_tick_pending <= 1'b0;
            end else if (w_tick && r_update_enable) begin
                r_tick_pending <= 1'b1;
            end
        end
    end

    always_comb begin
        w_set_mask = '0;
        w_clr_mask = '0;
        for (int i = 0; i < NUMBER_OF_MOTORS; i++) begin
            w_set_mask[i] = w_wr_cfg && (w_mi == IW'(i));
            w_clr_mask[i] = w_clr_cur && (r_idx == IW'(i));
        end
    end

    // Set has priority so a write racing the word-0 handshake is not lost
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_dirty <= '0;
        end else begin
            r_dirty <= (r_dirty & ~w_clr_mask) | w_set_mask;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_word  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_word  <= w_word_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_idx_nxt    = r_idx;
        w_word_nxt   = r_word;
        w_consume    = 1'b0;
        w_clr_cur    = 1'b0;
        w_frame_done = 1'b0;
        cfg_valid    = 1'b0;
        cfg_motor    = '0;
        cfg_word     = '0;
        cfg_data     = '0;
        cfg_last     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_tick_pending) begin
                    w_consume   = 1'b1;
                    w_idx_nxt   = '0;
                    w_state_nxt = S_SCAN;
                end
            end
            S_SCAN: begin
                if (r_dirty[r_idx]) begin
                    w_word_nxt  = '0;
                    w_state_nxt = S_SEND;
                end else if (r_idx == LAST_IDX) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_idx_nxt = r_idx + 1'b1;
                end
            end
            S_SEND: begin
                cfg_valid = 1'b1;
                cfg_motor = 8'(r_idx);
                cfg_word  = r_word;
                cfg_last  = (r_word == 3'd7);
                cfg_data  = (r_word == 3'd7) ? {29'd0, r_mode[r_idx]}
                                             : r_cfg[r_word][r_idx];
                if (cfg_ready) begin
                    w_clr_cur = (r_word == 3'd0);
                    if (r_word == 3'd7) begin
                        w_frame_done = 1'b1;
                        if (r_idx == LAST_IDX) begin
                            w_state_nxt = S_IDLE;
                        end else begin
                            w_idx_nxt   = r_idx + 1'b1;
                            w_state_nxt = S_SCAN;
                        end
                    end else begin
                        w_word_nxt = r_word + 3'd1;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_motor_control_regfile.sv
// Self-checking bench for motor_control_regfile: bus, status capture and
// config-frame streaming compared against a behavioural register/dirty model.
module tb_motor_control_regfile;

    localparam int N = 6;
    localparam int P = 16;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] address = '0;
    logic        write = 1'b0;
    logic [31:0] writedata = '0;
    logic        read = 1'b0;
    logic [31:0] readdata;
    logic        waitrequest;
    logic        status_valid = 1'b0;
    logic [7:0]  status_motor = '0;
    logic [31:0] status_position = '0;
    logic [31:0] status_velocity = '0;
    logic [15:0] status_current = '0;
    logic [31:0] status_displacement = '0;
    logic        cfg_valid;
    logic        cfg_ready = 1'b0;
    logic [7:0]  cfg_motor;
    logic [2:0]  cfg_word;
    logic [31:0] cfg_data;
    logic        cfg_last;

    always #5 clock = ~clock;

    motor_control_regfile #(
        .NUMBER_OF_MOTORS     (N),
        .UPDATE_PERIOD_CYCLES (P)
    ) dut (
        .clock               (clock),
        .reset               (reset),
        .address             (address),
        .write               (write),
        .writedata           (writedata),
        .read                (read),
        .readdata            (readdata),
        .waitrequest         (waitrequest),
        .status_valid        (status_valid),
        .status_motor        (status_motor),
        .status_position     (status_position),
        .status_velocity     (status_velocity),
        .status_current      (status_current),
        .status_displacement (status_displacement),
        .cfg_valid           (cfg_valid),
        .cfg_ready           (cfg_ready),
        .cfg_motor           (cfg_motor),
        .cfg_word            (cfg_word),
        .cfg_data            (cfg_data),
        .cfg_last            (cfg_last)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: words 0..7 per motor, word 7 holds the zero-extended mode
    logic [31:0] m_cfg  [N][8];
    logic [31:0] m_pos  [N];
    logic [31:0] m_vel  [N];
    logic [15:0] m_cur  [N];
    logic [31:0] m_disp [N];
    bit          m_dirty [N];
    bit          m_en;
    logic [31:0] m_frames;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int m = 0; m < N; m++) begin
            for (int w = 0; w < 8; w++) m_cfg[m][w] = '0;
            m_pos[m] = '0; m_vel[m] = '0; m_cur[m] = '0; m_disp[m] = '0;
            m_dirty[m] = 1'b0;
        end
        m_en = 1'b0;
        m_frames = '0;
    endfunction

    function automatic void model_write(input logic [15:0] a, input logic [31:0] d);
        int sel = int'(a[15:8]);
        int m   = int'(a[7:0]);
        if (sel <= 7 && m < N) begin
            m_cfg[m][sel] = (sel == 7) ? (d % 8) : d;
            m_dirty[m] = 1'b1;
        end else if (sel == 16) begin
            m_en = d[0];
        end
    endfunction

    function automatic logic [31:0] exp_rd(input logic [15:0] a);
        int sel = int'(a[15:8]);
        int m   = int'(a[7:0]);
        logic signed [31:0] cur;
        if (sel == 16) return {31'd0, m_en};
        if (sel == 17) return m_frames;
        if (sel > 11 || m >= N) return 32'hDEADBEEF;
        if (sel <= 7) return m_cfg[m][sel];
        if (sel == 8) return m_pos[m];
        if (sel == 9) return m_vel[m];
        if (sel == 11) return m_disp[m];
        cur = $signed(m_cur[m]);
        return cur;
    endfunction

    task automatic bus_write(input logic [15:0] a, input logic [31:0] d);
        @(negedge clock);
        address = a; writedata = d; write = 1'b1;
        @(negedge clock);
        write = 1'b0;
        model_write(a, d);
    endtask

    task automatic bus_read(input logic [15:0] a, input string tag);
        logic [31:0] e;
        @(negedge clock);
        address = a; read = 1'b1;
        e = exp_rd(a);
        #1 chk({tag, "_wait1"}, 64'(waitrequest), 64'd1);
        @(negedge clock);
        chk({tag, "_wait0"}, 64'(waitrequest), 64'd0);
        chk(tag, 64'(readdata), 64'(e));
        @(posedge clock);
        #1 read = 1'b0;
    endtask

    task automatic send_status(input int m, input logic [31:0] p, input logic [31:0] v,
                               input logic [15:0] c, input logic [31:0] d);
        @(negedge clock);
        status_valid = 1'b1; status_motor = 8'(m);
        status_position = p; status_velocity = v; status_current = c; status_displacement = d;
        @(negedge clock);
        status_valid = 1'b0;
        if (m < N) begin
            m_pos[m] = p; m_vel[m] = v; m_cur[m] = c; m_disp[m] = d;
        end
    endtask

    task automatic idle_check(input int cycles, input string tag);
        int seen = 0;
        cfg_ready = 1'b0;
        repeat (cycles) begin
            @(negedge clock);
            if (cfg_valid) seen++;
        end
        chk(tag, 64'(seen), 64'd0);
    endtask

    task automatic wait_valid(input string tag, output bit ok);
        int t = 0;
        cfg_ready = 1'b0;
        @(negedge clock);
        while (!cfg_valid && t < 300) begin
            @(negedge clock);
            t++;
        end
        ok = cfg_valid;
        chk(tag, 64'(cfg_valid), 64'd1);
    endtask

    // Expect one frame per dirty motor, in ascending motor order
    task automatic collect(input int stall_motor, input logic [31:0] kd_val);
        int exp_q[$];
        for (int m = 0; m < N; m++) if (m_dirty[m]) exp_q.push_back(m);
        while (exp_q.size() > 0) begin
            int m = exp_q.pop_front();
            bit ok;
            wait_valid("frame_start", ok);
            if (!ok) return;
            for (int w = 0; w < 8; w++) begin
                logic [44:0] snap;
                int k;
                bit do_wr;
                if (w > 0) @(negedge clock);
                chk("cfg_valid", 64'(cfg_valid), 64'd1);
                chk("cfg_motor", 64'(cfg_motor), 64'(m));
                chk("cfg_word", 64'(cfg_word), 64'(w));
                chk("cfg_data", 64'(cfg_data), 64'(m_cfg[m][w]));
                chk("cfg_last", 64'(cfg_last), 64'(w == 7));
                snap = {cfg_valid, cfg_motor, cfg_word, cfg_data, cfg_last};
                do_wr = (m == stall_motor) && (w == 3);
                k = do_wr ? 5 : int'($urandom_range(0, 2));
                for (int s = 0; s < k; s++) begin
                    cfg_ready = 1'b0;
                    if (do_wr && s == 0) begin
                        address = {8'h02, 8'(m)}; writedata = kd_val; write = 1'b1;
                    end
                    @(negedge clock);
                    if (write) begin
                        write = 1'b0;
                        model_write({8'h02, 8'(m)}, kd_val);
                    end
                    chk("hold_stable", 64'({cfg_valid, cfg_motor, cfg_word, cfg_data, cfg_last}),
                        64'(snap));
                end
                cfg_ready = 1'b1;
                @(posedge clock);
                if (w == 0) m_dirty[m] = 1'b0;
                if (w == 7) m_frames = m_frames + 32'd1;
                #1 cfg_ready = 1'b0;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [15:0] a;
        logic [31:0] d;
        logic [7:0]  sels [15];
        bit ok;
        sels = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
                 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h10, 8'h11, 8'h20};
        model_reset();

        repeat (2) @(negedge clock);
        chk("rst_readdata", 64'(readdata), 64'd0);
        chk("rst_waitrequest", 64'(waitrequest), 64'd0);
        chk("rst_cfg_valid", 64'(cfg_valid), 64'd0);
        chk("rst_cfg_fields", 64'({cfg_motor, cfg_word, cfg_data, cfg_last}), 64'd0);
        reset = 1'b0;

        bus_write(16'h0002, 32'h12345678);
        bus_read(16'h0002, "kp_m2");
        bus_read(16'h0006, "kp_m6_oob");
        bus_read(16'h2001, "unmapped");
        bus_read(16'h1100, "frames_rst");
        bus_write(16'h0801, 32'hCAFEF00D);
        bus_read(16'h0801, "ro_pos_write_ignored");
        bus_write(16'h0307, 32'h55555555);
        bus_read(16'h0307, "oob_write_ignored");
        bus_write(16'h0703, 32'hFFFFFFFD);
        bus_read(16'h0703, "mode_m3");

        send_status(1, $urandom, $urandom, 16'h8001, $urandom);
        bus_read(16'h0A01, "cur_sext_m1");
        bus_read(16'h0801, "pos_m1");
        bus_read(16'h0B01, "disp_m1");
        send_status(9, $urandom, $urandom, 16'h1234, $urandom);
        for (int m = 0; m < N; m++) bus_read({8'h0A, 8'(m)}, "cur_after_oob_status");
        send_status(4, $urandom, $urandom, 16'(($urandom)), $urandom);
        bus_read(16'h0904, "vel_m4");
        bus_read(16'h0A04, "cur_m4");

        for (int i = 0; i < 12; i++) begin
            a = {8'($urandom_range(0, 11)), 8'($urandom_range(0, 7))};
            d = $urandom;
            bus_write(a, d);
            a = {sels[$urandom_range(0, 14)], 8'($urandom_range(0, 7))};
            bus_read(a, "rand_read");
        end

        idle_check(60, "disabled_no_frames");
        bus_write(16'h1000, 32'h1);
        bus_read(16'h1000, "enable_read");
        collect(-1, 32'h0);
        bus_read(16'h1100, "frames_phase1");
        idle_check(40, "no_refresh_clean");

        bus_write(16'h1000, 32'h0);
        idle_check(20, "quiesce");
        bus_write(16'h0000, $urandom);
        bus_write(16'h0303, $urandom);
        bus_write(16'h0703, $urandom);
        bus_write(16'h1000, 32'h1);
        collect(3, $urandom);
        chk("m3_redirty", 64'(m_dirty[3]), 64'd1);
        collect(-1, 32'h0);
        bus_read(16'h0203, "kd_m3_mid_write");
        bus_read(16'h1100, "frames_phase2");
        idle_check(40, "no_refresh_after_resend");

        bus_write(16'h1000, 32'h0);
        idle_check(20, "quiesce2");
        bus_write(16'h0504, $urandom);
        bus_write(16'h1000, 32'h1);
        wait_valid("rst_frame_start", ok);
        if (ok) begin
            for (int w = 0; w < 4; w++) begin
                chk("pre_rst_word", 64'(cfg_word), 64'(w));
                cfg_ready = 1'b1;
                @(posedge clock);
                #1 cfg_ready = 1'b0;
                @(negedge clock);
            end
            chk("pre_rst_word4", 64'(cfg_word), 64'd4);
        end
        reset = 1'b1;
        #1;
        chk("async_rst_valid", 64'(cfg_valid), 64'd0);
        chk("async_rst_fields", 64'({cfg_motor, cfg_word, cfg_data, cfg_last}), 64'd0);
        chk("async_rst_readdata", 64'(readdata), 64'd0);
        model_reset();
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        bus_read(16'h0504, "post_rst_pwm_m4");
        bus_read(16'h0002, "post_rst_kp_m2");
        bus_read(16'h0A01, "post_rst_cur_m1");
        bus_read(16'h1000, "post_rst_enable");
        bus_read(16'h1100, "post_rst_frames");
        bus_write(16'h1000, 32'h1);
        idle_check(60, "no_frame_after_reset");
        bus_write(16'h0101, $urandom);
        collect(-1, 32'h0);
        bus_read(16'h1100, "frames_final");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
